eth_tlp_sched: RTL and testbench

//  Packet-atomic weighted round-robin scheduler between NUM_SRC PCIe tap FIFOs (FWFT, 74-bit words)
//  and the single encap FIFO in the clk156 domain. Grants one whole TLP at a time, tags each word with
//  its source id, bounds runaway TLPs with a beat watchdog. Sits between pcie2eth FIFOs and arb2encap_fifo.

---
 rtl/eth_tlpsched_pkg.sv | 25 ++
 rtl/eth_tlp_sched_rr_pick.sv | 31 +++
 rtl/eth_tlp_sched.sv | 180 ++++++++++++++++++
 tb/tb_eth_tlp_sched.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_tlpsched_pkg.sv
// Shared types for the PCIe-tap to encap TLP scheduler.
//   state_e    : scheduler FSM states
//   tlp_word_t : 74-bit tap FIFO word {user, last, keep[7:0], data[63:0]}
package eth_tlpsched_pkg;

  localparam int unsigned KEEP_LSB   = 64;
  localparam int unsigned LAST_BIT   = 72;
  localparam int unsigned USER_BIT   = 73;
  localparam int unsigned TLP_WORD_W = USER_BIT + 1;
  localparam int unsigned STAT_W     = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REFILL = 2'd1,
    ST_XFER   = 2'd2
  } state_e;

  typedef struct packed {
    logic                         user;
    logic                         last;
    logic [LAST_BIT-KEEP_LSB-1:0] keep;
    logic [KEEP_LSB-1:0]          data;
  } tlp_word_t;

endpackage

// File: rtl/eth_tlp_sched_rr_pick.sv
// Combinational rotating priority encoder.
//   req_i : request vector, one bit per source
//   ptr_i : highest-priority index for this scan
//   hit_o : some request is set
//   idx_o : first requester at or after ptr_i (wrapping)
module eth_rr_pick #(
  parameter int unsigned N     = 2,
  parameter int unsigned IDX_W = 1
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic             hit_o,
  output logic [IDX_W-1:0] idx_o
);

  always_comb begin
    logic [IDX_W-1:0] cand;
    hit_o = 1'b0;
    idx_o = '0;
    cand  = '0;
    // Walk from the farthest offset back towards ptr so the nearest requester wins.
    for (int k = N - 1; k >= 0; k--) begin
      cand = IDX_W'((32'(ptr_i) + 32'(k)) % N);
      if (req_i[cand]) begin
        hit_o = 1'b1;
        idx_o = cand;
      end
    end
  end

endmodule

// File: rtl/eth_tlp_sched.sv
// Packet-atomic weighted round-robin scheduler from NUM_SRC FWFT tap FIFOs
// into the single encap FIFO; whole TLPs are granted, words tagged with source id,
// runaway TLPs cut at MAX_BEATS words.
//   clk156/sys_rst_n : clock, async active-low reset
//   src_empty/src_dout/src_rd_en : FWFT source FIFOs (src_rd_en combinational)
//   cfg_weight       : TLPs per round per source, 0 disables
//   out_full/out_wr_en/out_din   : encap FIFO write side ({src_id, word})
//   busy, wdog_err   : transfer in progress, sticky watchdog flag
//   stat_pkts        : per-source TLP counters
// Optional: define ETH_TLPSCHED_STATS_EN to build stat_pkts counters (else tied 0).
module eth_tlp_sched
  import eth_tlpsched_pkg::*;
#(
  parameter int unsigned NUM_SRC   = 2,
  parameter int unsigned DATA_W    = TLP_WORD_W,
  parameter int unsigned SRC_ID_W  = 2,
  parameter int unsigned WEIGHT_W  = 4,
  parameter int unsigned MAX_BEATS = 512
) (
  input  logic                        clk156,
  input  logic                        sys_rst_n,
  input  logic [NUM_SRC-1:0]          src_empty,
  input  logic [NUM_SRC*DATA_W-1:0]   src_dout,
  output logic [NUM_SRC-1:0]          src_rd_en,
  input  logic [NUM_SRC*WEIGHT_W-1:0] cfg_weight,
  input  logic                        out_full,
  output logic                        out_wr_en,
  output logic [SRC_ID_W+DATA_W-1:0]  out_din,
  output logic                        busy,
  output logic                        wdog_err,
  output logic [NUM_SRC*STAT_W-1:0]   stat_pkts
);

  localparam int unsigned IDX_W  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int unsigned BEAT_W = $clog2(MAX_BEATS);
  localparam int unsigned OUT_W  = SRC_ID_W + DATA_W;

  state_e                           state_q, state_d;
  logic [IDX_W-1:0]                 rr_ptr_q, rr_ptr_d, gnt_q, gnt_d, pick_idx;
  logic [BEAT_W-1:0]                beat_cnt_q, beat_cnt_d;
  logic [NUM_SRC-1:0][WEIGHT_W-1:0] credit_q, credit_d, weight_c;
  logic [NUM_SRC-1:0]               req_c, elig_c;
  logic                             pick_hit, pop_c, wdog_hit_c, tlp_end_c;
  tlp_word_t [NUM_SRC-1:0]          src_word;
  tlp_word_t                        gnt_word_c, out_word_c;
  logic                             out_wr_en_q, out_wr_en_d;
  logic [OUT_W-1:0]                 out_din_q, out_din_d;
  logic                             busy_q, busy_d;
  logic                             wdog_err_q, wdog_err_d;

  assign src_word   = src_dout;
  assign weight_c   = cfg_weight;
  assign gnt_word_c = src_word[gnt_q];

  // Grantable now (credit left) vs. worth a refill (weight nonzero).
  always_comb begin
    req_c  = '0;
    elig_c = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      req_c[i]  = !src_empty[i] && (credit_q[i] != '0);
      elig_c[i] = !src_empty[i] && (weight_c[i] != '0);
    end
  end

  eth_rr_pick #(.N(NUM_SRC), .IDX_W(IDX_W)) u_pick (
    .req_i (req_c),
    .ptr_i (rr_ptr_q),
    .hit_o (pick_hit),
    .idx_o (pick_idx)
  );

  assign pop_c      = (state_q == ST_XFER) && !src_empty[gnt_q] && !out_full;
  assign wdog_hit_c = (beat_cnt_q == BEAT_W'(MAX_BEATS - 1));
  assign tlp_end_c  = pop_c && (gnt_word_c.last || wdog_hit_c);

  // FSM state register.
  always_ff @(posedge clk156 or negedge sys_rst_n) begin
    if (!sys_rst_n) state_q <= ST_IDLE;
    else            state_q <= state_d;
  end

  // FSM next state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (pick_hit)       state_d = ST_XFER;
        else if (|elig_c)   state_d = ST_REFILL;
      end
      ST_REFILL:            state_d = ST_IDLE;
      ST_XFER: begin
        if (tlp_end_c)      state_d = ST_IDLE;
      end
      default:              state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: pop strobe to the granted source, busy follows the next state.
  always_comb begin
    src_rd_en = '0;
    if (pop_c) src_rd_en[gnt_q] = 1'b1;
    busy_d = (state_d == ST_XFER);
  end

  // Grant, credits, beat counter and output word.
  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    gnt_d       = gnt_q;
    beat_cnt_d  = beat_cnt_q;
    credit_d    = credit_q;
    out_wr_en_d = pop_c;
    out_din_d   = out_din_q;
    wdog_err_d  = wdog_err_q;
    out_word_c      = gnt_word_c;
    out_word_c.last = gnt_word_c.last | wdog_hit_c;

    if ((state_q == ST_IDLE) && pick_hit) begin
      gnt_d      = pick_idx;
      beat_cnt_d = '0;
    end
    if (state_q == ST_REFILL) credit_d = weight_c;
    if (pop_c) begin
      beat_cnt_d = beat_cnt_q + BEAT_W'(1);
      out_din_d  = {SRC_ID_W'(gnt_q), out_word_c};
    end
    if (tlp_end_c) begin
      if (credit_q[gnt_q] != '0) credit_d[gnt_q] = credit_q[gnt_q] - WEIGHT_W'(1);
      rr_ptr_d = (gnt_q == IDX_W'(NUM_SRC - 1)) ? '0 : gnt_q + IDX_W'(1);
      // A word that carries its own last on the final allowed beat is a clean end.
      if (wdog_hit_c && !gnt_word_c.last) wdog_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk156 or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rr_ptr_q    <= '0;
      gnt_q       <= '0;
      beat_cnt_q  <= '0;
      credit_q    <= '0;
      out_wr_en_q <= 1'b0;
      out_din_q   <= '0;
      busy_q      <= 1'b0;
      wdog_err_q  <= 1'b0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      gnt_q       <= gnt_d;
      beat_cnt_q  <= beat_cnt_d;
      credit_q    <= credit_d;
      out_wr_en_q <= out_wr_en_d;
      out_din_q   <= out_din_d;
      busy_q      <= busy_d;
      wdog_err_q  <= wdog_err_d;
    end
  end

  assign out_wr_en = out_wr_en_q;
  assign out_din   = out_din_q;
  assign busy      = busy_q;
  assign wdog_err  = wdog_err_q;

`ifdef ETH_TLPSCHED_STATS_EN
  logic [NUM_SRC-1:0][STAT_W-1:0] stat_q, stat_d;

  // Count every TLP end, watchdog-terminated ones included; wraps naturally.
  always_comb begin
    stat_d = stat_q;
    if (tlp_end_c) stat_d[gnt_q] = stat_q[gnt_q] + STAT_W'(1);
  end

  always_ff @(posedge clk156 or negedge sys_rst_n) begin
    if (!sys_rst_n) stat_q <= '0;
    else            stat_q <= stat_d;
  end

  assign stat_pkts = stat_q;
`else
  assign stat_pkts = '0;
`endif

endmodule

// File: tb/tb_eth_tlp_sched.sv
module tb_eth_tlp_sched;

  localparam int unsigned NS   = 2;
  localparam int unsigned DW   = 74;
  localparam int unsigned IW   = 2;
  localparam int unsigned WW   = 4;
  localparam int unsigned MAXB = 16;
  localparam int unsigned OW   = IW + DW;

  logic             clk156 = 1'b0;
  logic             sys_rst_n;
  logic [NS-1:0]    src_empty, src_rd_en;
  logic [NS*DW-1:0] src_dout;
  logic [NS*WW-1:0] cfg_weight;
  logic             out_full, out_wr_en, busy, wdog_err;
  logic [OW-1:0]    out_din;
  logic [NS*32-1:0] stat_pkts;

  eth_tlp_sched #(
    .NUM_SRC(NS), .DATA_W(DW), .SRC_ID_W(IW), .WEIGHT_W(WW), .MAX_BEATS(MAXB)
  ) dut (
    .clk156(clk156), .sys_rst_n(sys_rst_n), .src_empty(src_empty), .src_dout(src_dout),
    .src_rd_en(src_rd_en), .cfg_weight(cfg_weight), .out_full(out_full),
    .out_wr_en(out_wr_en), .out_din(out_din), .busy(busy), .wdog_err(wdog_err),
    .stat_pkts(stat_pkts)
  );

  always #5 clk156 = ~clk156;

  int n_cmp = 0;
  int n_err = 0;

  // Source FIFO contents seen by the DUT, and the reference model's own copy.
  logic [DW-1:0] fq[NS][$];
  logic [DW-1:0] mq[NS][$];
  logic [OW-1:0] exp_q[$];
  int unsigned   m_w[NS];
  int unsigned   m_credit[NS];
  int unsigned   m_stats[NS];
  int unsigned   m_ptr;
  bit            m_wdog;
  bit            pop_pend;
  int            pop_idx;
  int            full_mode;
  int            wr_cnt;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NS; i++) begin
      m_credit[i] = 0;
      m_stats[i]  = 0;
    end
    m_ptr  = 0;
    m_wdog = 1'b0;
  endtask

  // Packet-level WRR: consume whole TLPs from mq into the expected write stream.
  task automatic model_run();
    for (int guard = 0; guard < 1000; guard++) begin
      bit hit = 1'b0;
      bit any = 1'b0;
      int g = 0;
      for (int k = 0; k < NS; k++) begin
        int i = (m_ptr + k) % NS;
        if (!hit && mq[i].size() > 0 && m_credit[i] > 0) begin
          hit = 1'b1;
          g   = i;
        end
      end
      if (!hit) begin
        for (int i = 0; i < NS; i++) if (mq[i].size() > 0 && m_w[i] > 0) any = 1'b1;
        if (!any) break;
        for (int i = 0; i < NS; i++) m_credit[i] = m_w[i];
        continue;
      end
      for (int b = 0; b < MAXB; b++) begin
        logic [DW-1:0] w;
        bit last;
        if (mq[g].size() == 0) break;
        w    = mq[g].pop_front();
        last = w[72];
        if (b == MAXB - 1) begin
          if (!last) m_wdog = 1'b1;
          w[72] = 1'b1;
          last  = 1'b1;
        end
        exp_q.push_back({IW'(g), w});
        if (last) break;
      end
      m_credit[g]--;
      m_ptr = (g + 1) % NS;
      m_stats[g]++;
    end
  endtask

  task automatic set_weights(input int unsigned w0, input int unsigned w1);
    m_w[0] = w0;
    m_w[1] = w1;
    cfg_weight = {WW'(w1), WW'(w0)};
  endtask

  task automatic load_tlp(input int src, input int len, input bit with_last);
    for (int b = 0; b < len; b++) begin
      logic [DW-1:0] w;
      w = {1'($urandom), 1'(with_last && (b == len - 1)), 8'($urandom), $urandom, $urandom};
      fq[src].push_back(w);
      mq[src].push_back(w);
    end
  endtask

  task automatic drive_srcs();
    for (int i = 0; i < NS; i++) begin
      src_empty[i]         = (fq[i].size() == 0);
      src_dout[i*DW +: DW] = (fq[i].size() == 0) ? '0 : fq[i][0];
    end
  endtask

  task automatic check_stats();
    for (int i = 0; i < NS; i++) begin
      logic [31:0] e;
`ifdef ETH_TLPSCHED_STATS_EN
      e = m_stats[i];
`else
      e = '0;
`endif
      chk($sformatf("stat_pkts%0d", i), stat_pkts[i*32 +: 32], e);
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_wr_en"}, out_wr_en, 0);
    chk({tag, "_din"}, out_din, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_wdog"}, wdog_err, 0);
    chk({tag, "_rd_en"}, src_rd_en, 0);
    chk({tag, "_stats"}, stat_pkts, 0);
  endtask

  // One clock: inputs at negedge, pop decision just after, outputs #1 after posedge.
  task automatic cycle();
    @(negedge clk156);
    if (pop_pend && fq[pop_idx].size() > 0) fq[pop_idx].delete(0);
    case (full_mode)
      1:       out_full = ($urandom_range(0, 9) < 3);
      2:       out_full = ~out_full;
      default: out_full = 1'b0;
    endcase
    drive_srcs();
    #1;
    pop_pend = 1'b0;
    if (out_full) chk("rd_while_full", src_rd_en, 0);
    if (src_rd_en != '0) begin
      chk("rd_onehot", $countones(src_rd_en), 1);
      chk("rd_on_empty", src_rd_en & src_empty, 0);
      pop_pend = 1'b1;
      for (int i = 0; i < NS; i++) if (src_rd_en[i]) pop_idx = i;
    end
    @(posedge clk156);
    #1;
    chk("wr_latency", out_wr_en, pop_pend);
    if (out_wr_en) begin
      wr_cnt++;
      if (exp_q.size() == 0) chk("extra_write", 1, 0);
      else begin
        logic [OW-1:0] e;
        e = exp_q.pop_front();
        chk("out_din", out_din, e);
        chk("busy_on_write", busy, !e[72]);
      end
    end
  endtask

  task automatic run_phase(input int fm);
    int budget = 0;
    int exp_cnt;
    full_mode = fm;
    model_run();
    exp_cnt = exp_q.size();
    wr_cnt  = 0;
    while ((exp_q.size() != 0 || busy) && budget < 3000) begin
      cycle();
      budget++;
    end
    if (budget >= 3000) begin
      chk("drain_timeout", 1, 0);
      exp_q.delete();
    end
    full_mode = 0;
    repeat (6) cycle();
    chk("write_count", wr_cnt, exp_cnt);
    for (int i = 0; i < NS; i++) chk($sformatf("fifo_left%0d", i), fq[i].size(), mq[i].size());
    chk("wdog_err", wdog_err, m_wdog);
    check_stats();
  endtask

  initial begin
    int budget;
    bit seen;
    sys_rst_n  = 1'b0;
    out_full   = 1'b0;
    cfg_weight = '0;
    pop_pend   = 1'b0;
    pop_idx    = 0;
    full_mode  = 0;
    m_w[0] = 0;
    m_w[1] = 0;
    model_reset();
    drive_srcs();
    repeat (3) @(negedge clk156);
    #1;
    check_reset("por");
    @(negedge clk156);
    sys_rst_n = 1'b1;

    // Single 3-beat TLP from src0 after a refill.
    set_weights(1, 1);
    load_tlp(0, 3, 1'b1);
    run_phase(0);

    // Both backlogged, weights 3:1, random backpressure.
    set_weights(3, 1);
    for (int t = 0; t < 6; t++) load_tlp(0, $urandom_range(1, 6), 1'b1);
    for (int t = 0; t < 3; t++) load_tlp(1, $urandom_range(1, 6), 1'b1);
    run_phase(1);

    // 8-beat TLP with out_full toggling every cycle.
    set_weights(1, 1);
    load_tlp(0, 8, 1'b1);
    run_phase(2);

    // Runaway TLP on src1 cut by the watchdog, then normal traffic.
    set_weights(1, 1);
    load_tlp(1, MAXB, 1'b0);
    load_tlp(1, 2, 1'b1);
    load_tlp(0, 3, 1'b1);
    run_phase(1);

    // src0 disabled by zero weight; src1 gets two per round.
    set_weights(0, 2);
    for (int t = 0; t < 2; t++) load_tlp(0, $urandom_range(1, 5), 1'b1);
    for (int t = 0; t < 4; t++) load_tlp(1, $urandom_range(1, 5), 1'b1);
    run_phase(1);
    chk("zero_weight_idle", busy, 0);

    // Asynchronous reset in the middle of a TLP.
    set_weights(1, 1);
    load_tlp(1, 10, 1'b1);
    full_mode = 1;
    model_run();
    budget = 0;
    seen   = 1'b0;
    while (!seen && budget < 300) begin
      cycle();
      budget++;
      if (out_wr_en && busy) seen = 1'b1;
    end
    chk("mid_tlp_reached", seen, 1);
    @(negedge clk156);
    sys_rst_n = 1'b0;
    #1;
    check_reset("rst_mid");
    for (int i = 0; i < NS; i++) begin
      fq[i].delete();
      mq[i].delete();
    end
    exp_q.delete();
    pop_pend  = 1'b0;
    full_mode = 0;
    out_full  = 1'b0;
    model_reset();
    drive_srcs();
    repeat (2) @(negedge clk156);
    sys_rst_n = 1'b1;

    // Random weights and traffic after reset.
    for (int r = 0; r < 3; r++) begin
      set_weights($urandom_range(1, 3), $urandom_range(1, 3));
      for (int s = 0; s < NS; s++)
        for (int t = 0; t < int'($urandom_range(3, 5)); t++)
          load_tlp(s, $urandom_range(1, 12), 1'b1);
      run_phase(1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
